// File: rtl/bist_pkg.sv
// Shared constants for the 3-input BIST checker: state encoding, pattern space
// and the expected-response function of the device under test.
package bist_pkg;

   localparam int unsigned NUM_PATTERNS = 8;
   localparam int unsigned PAT_W        = 3;
   localparam int unsigned ERR_W        = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Golden response: high only for pattern 110.
   function automatic logic expected_d(input logic [PAT_W-1:0] pat);
      return pat[2] & pat[1] & ~pat[0];
   endfunction

endpackage

// File: rtl/bist_hold_timer.sv
// Per-pattern hold counter: flags the settle sample point and the last hold
// cycle of each pattern while the checker is running.
module bist_hold_timer
   import bist_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 5,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic sample_now,
   output logic pattern_end
);

   localparam int unsigned CNT_W = 4;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign sample_now  = run && (cnt_q == CNT_W'(SETTLE_CYCLES));
   assign pattern_end = run && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = pattern_end ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bist_3in_checker.sv
// BIST sequencer for a 3-input combinational DUT: walks patterns 000..111,
// samples the response once per pattern and keeps a mismatch scoreboard.
module bist_3in_checker
   import bist_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 5,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_c,
   input  logic             dut_d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [PAT_W-1:0] first_fail,
   output logic             first_fail_valid,
   output logic             d_correct
);

   logic [1:0]       state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [PAT_W-1:0] first_fail_q, first_fail_d;
   logic             ffv_q, ffv_d;
   logic             pass_q, pass_d;
   logic             d_correct_q, d_correct_d;

   logic launch;
   logic running;
   logic sample_now;
   logic pattern_end;
   logic match;

   assign running = (state_q == ST_APPLY);
   assign launch  = start && !running;
   assign match   = (dut_d == expected_d(pattern_q));

   bist_hold_timer #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .clear       (launch),
      .run         (running),
      .sample_now  (sample_now),
      .pattern_end (pattern_end)
   );

   always_comb begin
      state_d      = state_q;
      pattern_d    = pattern_q;
      err_count_d  = err_count_q;
      first_fail_d = first_fail_q;
      ffv_d        = ffv_q;
      pass_d       = pass_q;
      d_correct_d  = d_correct_q;

      case (state_q)
         ST_APPLY: begin
            if (sample_now) begin
               d_correct_d = match;
               if (!match) begin
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 1'b1;
                  end
                  if (!ffv_q) begin
                     first_fail_d = pattern_q;
                     ffv_d        = 1'b1;
                  end
               end
            end
            // Sample and end-of-pattern may share an edge, so pass uses the updated count.
            if (pattern_end) begin
               if (pattern_q == PAT_W'(NUM_PATTERNS - 1)) begin
                  state_d = ST_DONE;
                  pass_d  = (err_count_d == '0);
               end else begin
                  pattern_d = pattern_q + 1'b1;
               end
            end
         end
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_APPLY;
               pattern_d    = '0;
               err_count_d  = '0;
               first_fail_d = '0;
               ffv_d        = 1'b0;
               pass_d       = 1'b0;
               d_correct_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pattern_q    <= '0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         ffv_q        <= 1'b0;
         pass_q       <= 1'b0;
         d_correct_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pattern_q    <= pattern_d;
         err_count_q  <= err_count_d;
         first_fail_q <= first_fail_d;
         ffv_q        <= ffv_d;
         pass_q       <= pass_d;
         d_correct_q  <= d_correct_d;
      end
   end

   assign {dut_a, dut_b, dut_c} = running ? pattern_q : '0;
   assign busy             = running;
   assign done             = (state_q == ST_DONE);
   assign pass             = pass_q;
   assign err_count        = err_count_q;
   assign first_fail       = first_fail_q;
   assign first_fail_valid = ffv_q;
   assign d_correct        = d_correct_q;

endmodule

// File: tb/tb_bist_3in_checker.sv
// Directed bench for bist_3in_checker: default instance with selectable DUT
// behaviour, plus two fast instances driving a 2-cycle-delayed DUT model.
module tb_bist_3in_checker;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Main instance (defaults); dut_mode 0 = correct, 1 = stuck-at-0, 2 = inverted
   int       dut_mode = 0;
   logic     start_m = 1'b0;
   logic     a_m, b_m, c_m, d_m, busy_m, done_m, pass_m, ffv_m, dc_m;
   logic [3:0] err_m;
   logic [2:0] ff_m;
   logic     good_m;

   assign good_m = a_m & b_m & ~c_m;
   assign d_m = (dut_mode == 0) ? good_m : (dut_mode == 1) ? 1'b0 : ~good_m;

   bist_3in_checker u_main (
      .clk(clk), .reset(reset), .start(start_m),
      .dut_a(a_m), .dut_b(b_m), .dut_c(c_m), .dut_d(d_m),
      .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
      .first_fail(ff_m), .first_fail_valid(ffv_m), .d_correct(dc_m)
   );

   // Fast instances: HOLD=3 with SETTLE=1 and SETTLE=2, DUT response delayed 2 cycles
   logic start_f = 1'b0;
   logic a_1, b_1, c_1, busy_1, done_1, pass_1, ffv_1, dc_1, d1_1, d2_1;
   logic a_2, b_2, c_2, busy_2, done_2, pass_2, ffv_2, dc_2, d1_2, d2_2;
   logic [3:0] err_1, err_2;
   logic [2:0] ff_1, ff_2;

   always_ff @(posedge clk) begin
      if (reset) begin
         d1_1 <= 1'b0; d2_1 <= 1'b0; d1_2 <= 1'b0; d2_2 <= 1'b0;
      end else begin
         d1_1 <= a_1 & b_1 & ~c_1; d2_1 <= d1_1;
         d1_2 <= a_2 & b_2 & ~c_2; d2_2 <= d1_2;
      end
   end

   bist_3in_checker #(.HOLD_CYCLES(3), .SETTLE_CYCLES(1)) u_fast1 (
      .clk(clk), .reset(reset), .start(start_f),
      .dut_a(a_1), .dut_b(b_1), .dut_c(c_1), .dut_d(d2_1),
      .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
      .first_fail(ff_1), .first_fail_valid(ffv_1), .d_correct(dc_1)
   );

   bist_3in_checker #(.HOLD_CYCLES(3), .SETTLE_CYCLES(2)) u_fast2 (
      .clk(clk), .reset(reset), .start(start_f),
      .dut_a(a_2), .dut_b(b_2), .dut_c(c_2), .dut_d(d2_2),
      .busy(busy_2), .done(done_2), .pass(pass_2), .err_count(err_2),
      .first_fail(ff_2), .first_fail_valid(ffv_2), .d_correct(dc_2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start on the main instance; returns cycles from start edge to done.
   task automatic run_main(output int cycles, output logic dc_seen);
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      cycles  = 0;
      dc_seen = 1'b0;
      while (!done_m && cycles < 200) begin
         tick();
         cycles++;
         if (dc_m) dc_seen = 1'b1;
      end
   endtask

   int   cyc, cyc1, cyc2;
   logic seen;

   initial begin
      // Reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_pass", pass_m, 0);
      check("rst_err", err_m, 0);
      check("rst_ff", ff_m, 0);
      check("rst_ffv", ffv_m, 0);
      check("rst_dc", dc_m, 0);
      check("rst_pat", {a_m, b_m, c_m}, 0);

      // Correct DUT: 40-cycle run, pass
      dut_mode = 0;
      run_main(cyc, seen);
      check("good_len", cyc, 40);
      check("good_pass", pass_m, 1);
      check("good_err", err_m, 0);
      check("good_ffv", ffv_m, 0);
      check("good_dc", dc_m, 1);
      check("good_busy", busy_m, 0);
      check("good_pat", {a_m, b_m, c_m}, 0);

      // Stuck-at-0 DUT
      dut_mode = 1;
      run_main(cyc, seen);
      check("sa0_len", cyc, 40);
      check("sa0_err", err_m, 1);
      check("sa0_ff", ff_m, 3'b110);
      check("sa0_ffv", ffv_m, 1);
      check("sa0_pass", pass_m, 0);

      // Inverted DUT; results hold in DONE
      dut_mode = 2;
      run_main(cyc, seen);
      check("inv_err", err_m, 8);
      check("inv_ff", ff_m, 3'b000);
      check("inv_pass", pass_m, 0);
      check("inv_dc_seen", seen, 0);
      check("inv_dc", dc_m, 0);
      tick(); tick(); tick();
      check("inv_hold_done", done_m, 1);
      check("inv_hold_err", err_m, 8);

      // Reset on cycle 17 of an inverted run, then a clean run
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check("abort_pre_err", err_m, 3);
      check("abort_pre_pat", {a_m, b_m, c_m}, 3'b011);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy_m, 0);
      check("abort_done", done_m, 0);
      check("abort_pat", {a_m, b_m, c_m}, 0);
      check("abort_err", err_m, 0);
      dut_mode = 0;
      run_main(cyc, seen);
      check("post_abort_len", cyc, 40);
      check("post_abort_pass", pass_m, 1);

      // Start pulse during pattern 011 is ignored
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check("ign_pre_pat", {a_m, b_m, c_m}, 3'b011);
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      cyc = 17;
      check("ign_pat", {a_m, b_m, c_m}, 3'b011);
      check("ign_busy", busy_m, 1);
      while (!done_m && cyc < 200) begin
         tick();
         cyc++;
         if (cyc % 5 == 0 && cyc < 40)
            check("ign_seq", {a_m, b_m, c_m}, 32'(cyc / 5));
      end
      check("ign_len", cyc, 40);
      check("ign_pass", pass_m, 1);

      // Fast instances with delayed DUT response
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      cyc1 = 0; cyc2 = 0; cyc = 0;
      while (!(done_1 && done_2) && cyc < 100) begin
         tick();
         cyc++;
         if (done_1 && cyc1 == 0) cyc1 = cyc;
         if (done_2 && cyc2 == 0) cyc2 = cyc;
      end
      check("f1_len", cyc1, 24);
      check("f2_len", cyc2, 24);
      check("f1_err", err_1, 2);
      check("f1_ff", ff_1, 3'b110);
      check("f1_ffv", ffv_1, 1);
      check("f1_pass", pass_1, 0);
      check("f2_err", err_2, 0);
      check("f2_pass", pass_2, 1);
      check("f2_ffv", ffv_2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
